// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader.
//   - default BRAM geometry (word width, depth)
//   - clogb2 helper used to derive the address width
//   - FSM state encoding
package bram_stream_reader_pkg;

   localparam int DEF_RAM_WIDTH = 128;
   localparam int DEF_RAM_DEPTH = 256;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Number of bits needed to hold the value 'depth' (clogb2(255) = 8).
   function automatic int clogb2(input int depth);
      int d;
      int r;
      d = depth;
      r = 0;
      while (d > 0) begin
         r = r + 1;
         d = d >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bram_stream_reader_fifo2.sv
// stream_fifo2: 2-entry synchronous FIFO carrying a data word plus a
// last flag. The writer guarantees it never pushes into a full FIFO
// unless a pop happens in the same cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push            write push_data/push_last
//   push_data       word to store
//   push_last       last-of-burst flag to store
//   pop             remove head entry (ignored when empty)
//   valid           FIFO holds at least one entry
//   data, last      head entry
//   count           occupancy 0..2
module stream_fifo2 #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_last,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             last,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_data [2];
   logic [1:0]       mem_last;
   logic             wr_ptr;
   logic             rd_ptr;
   logic             pop_ok;

   assign pop_ok = pop && (count != 2'd0);
   assign valid  = (count != 2'd0);
   assign data   = mem_data[rd_ptr];
   // Gate with valid so a stale flag never shows on an empty FIFO.
   assign last   = valid && mem_last[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_data[0] <= '0;
         mem_data[1] <= '0;
         mem_last    <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a burst of words from a simple dual-port
// BRAM read port and presents them on a valid/ready stream.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_base, cmd_len     first address, number of words (0..RAM_DEPTH)
//   enb, addrb            BRAM read enable / address (registered)
//   doutb                 BRAM read data, valid one cycle after enb
//   m_valid/m_ready       output stream handshake
//   m_data, m_last        output word, last-word marker
//   busy                  high outside IDLE
//   done                  one-cycle pulse when a burst completes
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// RUN      | issuing reads while words remain
// DRAIN    | all reads issued, waiting for FIFO and in-flight read
// DONE     | done pulse, back to IDLE next cycle
module bram_stream_reader
   import bram_stream_reader_pkg::*;
#(
   parameter int RAM_WIDTH = DEF_RAM_WIDTH,
   parameter int RAM_DEPTH = DEF_RAM_DEPTH,
   parameter int ADDR_W    = clogb2(RAM_DEPTH - 1),
   parameter int LEN_W     = ADDR_W + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ADDR_W-1:0]    cmd_base,
   input  logic [LEN_W-1:0]     cmd_len,
   output logic                 enb,
   output logic [ADDR_W-1:0]    addrb,
   input  logic [RAM_WIDTH-1:0] doutb,
   output logic                 m_valid,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic              inflight;
   logic              inflight_last;
   logic [1:0]        fifo_count;
   logic [2:0]        occ;
   logic              pop;
   logic              issue;
   logic              accept;
   logic              drain_done;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign enb       = inflight;

   assign accept = cmd_valid && cmd_ready;
   assign pop    = m_valid && m_ready;

   // Slots already committed: words in the FIFO plus the read whose data
   // lands at the next edge. A pop this cycle frees one slot, which is
   // what allows one word per cycle in steady state.
   assign occ   = {1'b0, fifo_count} + {2'b00, inflight};
   assign issue = (state == ST_RUN) && (remaining != '0) &&
                  ((occ < 3'd2) || ((occ == 3'd2) && pop));

   // FIFO will be empty after this edge and no read data is still coming.
   assign drain_done = !inflight &&
                       ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         addr          <= '0;
         addrb         <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            addrb         <= addr;
            addr          <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            remaining     <= remaining - LEN_W'(1);
            inflight_last <= (remaining == LEN_W'(1));
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  addr      <= cmd_base;
                  remaining <= cmd_len;
                  state     <= (cmd_len == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (remaining == '0) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read data is captured one edge after the read is issued.
   stream_fifo2 #(
      .WIDTH (RAM_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (doutb),
      .push_last (inflight_last),
      .pop       (pop),
      .valid     (m_valid),
      .data      (m_data),
      .last      (m_last),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM
// (bram[i] = i, read sampled on the falling edge).
module tb_bram_stream_reader;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [7:0]   cmd_base = '0;
   logic [8:0]   cmd_len = '0;
   logic         enb;
   logic [7:0]   addrb;
   logic [127:0] doutb = '0;
   logic         m_valid;
   logic [127:0] m_data;
   logic         m_last;
   logic         m_ready = 1'b1;
   logic         busy;
   logic         done;

   logic [127:0] bram [256];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bram_stream_reader dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_base  (cmd_base),
      .cmd_len   (cmd_len),
      .enb       (enb),
      .addrb     (addrb),
      .doutb     (doutb),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .busy      (busy),
      .done      (done)
   );

   always @(negedge clk) begin
      if (enb) doutb <= bram[addrb];
   end

   always @(posedge clk) begin
      if (cmd_valid) begin
         assert (cmd_len <= 9'd256) else begin
            miscompares++;
            $error("FAIL cmd_len_range: observed %0d required <= 256", cmd_len);
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      chk({tag, "_enb"},       enb,       1'b0);
      chk({tag, "_addrb"},     addrb,     8'd0);
      chk({tag, "_m_valid"},   m_valid,   1'b0);
      chk({tag, "_m_data"},    m_data,    128'd0);
      chk({tag, "_m_last"},    m_last,    1'b0);
      chk({tag, "_busy"},      busy,      1'b0);
      chk({tag, "_done"},      done,      1'b0);
   endtask

   // Runs one burst. toggle selects the m_ready pattern 1,0,0,1,0,1,...
   // abort_after > 0 stops after that many beats with rst driven high.
   task automatic run_burst(input int base, input int len, input bit toggle,
                            input int abort_after);
      int           beats = 0;
      int           cyc = 0;
      int           first_valid = -1;
      int           issued = 0;
      int           exp_addr;
      int           budget;
      logic [127:0] held_data = '0;
      logic         held_last = 1'b0;
      bit           stalled = 1'b0;
      bit           last_hs = 1'b0;
      bit           finished = 1'b0;
      logic [5:0]   pat = 6'b101001;

      budget = 4 * len + 20;
      while (!cmd_ready && cyc < 20) begin
         step();
         cyc++;
      end
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_base  = 8'(base);
      cmd_len   = 9'(len);
      step();
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
      chk("cmd_ready_while_busy", cmd_ready, 1'b0);

      if (len == 0) begin
         chk("done_len0", done, 1'b1);
         chk("m_valid_len0", m_valid, 1'b0);
         step();
         chk("done_pulse_len0", done, 1'b0);
         chk("cmd_ready_after_done_len0", cmd_ready, 1'b1);
         return;
      end

      exp_addr = base;
      cyc = 0;
      while (cyc < budget) begin
         if (enb) begin
            chk("addrb", addrb, 128'(exp_addr % 256));
            exp_addr++;
            issued++;
         end
         if (stalled) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, held_data);
            chk("hold_last", m_last, held_last);
         end
         if (last_hs) begin
            chk("done_after_last", done, 1'b1);
            finished = 1'b1;
            break;
         end
         if (done) chk("early_done", done, 1'b0);
         if (abort_after > 0 && beats == abort_after) begin
            rst = 1'b1;
            return;
         end
         if (m_valid && first_valid < 0) first_valid = cyc;
         m_ready = toggle ? pat[cyc % 6] : 1'b1;
         if (m_valid && m_ready) begin
            chk("data", m_data, 128'((base + beats) % 256));
            chk("last", m_last, (beats == len - 1));
            beats++;
            last_hs = (beats == len);
            stalled = 1'b0;
         end else if (m_valid) begin
            stalled   = 1'b1;
            held_data = m_data;
            held_last = m_last;
         end else begin
            stalled = 1'b0;
         end
         step();
         cyc++;
      end

      chk("burst_complete", finished, 1'b1);
      chk("beat_count", 128'(beats), 128'(len));
      chk("issue_count", 128'(issued), 128'(len));
      if (!toggle) begin
         chk("first_valid_latency", 128'(first_valid), 128'(2));
         chk("back_to_back", 128'(cyc - first_valid), 128'(len));
      end
      m_ready = 1'b1;
      step();
      chk("done_one_cycle", done, 1'b0);
      chk("cmd_ready_after_done", cmd_ready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) bram[i] = 128'(i);

      rst = 1'b1;
      step();
      step();
      chk_reset_values("reset");
      rst = 1'b0;
      step();

      run_burst(0, 4, 1'b0, 0);
      run_burst(254, 4, 1'b0, 0);
      run_burst(10, 6, 1'b1, 0);
      run_burst(0, 0, 1'b0, 0);
      run_burst(0, 256, 1'b0, 0);

      run_burst(0, 8, 1'b0, 3);
      step();
      chk_reset_values("mid_reset");
      rst = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_reset_no_done", done, 1'b0);
         chk("post_reset_no_valid", m_valid, 1'b0);
      end
      run_burst(100, 2, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read-side companion for the simple dual-port BRAM. Accepts a burst command (base address, word count), drives the BRAM read port (enb/addrb), absorbs the BRAM read latency, and emits words on a valid/ready stream with backpressure. Sits between a BRAM buffer (weights, activations, results) and the consumer feeding the systolic array or the output path.

Parameters:
RAM_WIDTH, 128, data word width; must equal the BRAM RAM_WIDTH.
RAM_DEPTH, 256, BRAM entries; must equal the BRAM RAM_DEPTH.
ADDR_W, clogb2(RAM_DEPTH-1), derived address width (8 at default).
LEN_W, ADDR_W+1, command length width; allows lengths 0..RAM_DEPTH.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offer.
cmd_ready  out  1  high only in IDLE.
cmd_base  in  ADDR_W  first read address.
cmd_len  in  LEN_W  number of words to read.
enb  out  1  BRAM read enable.
addrb  out  ADDR_W  BRAM read address.
doutb  in  RAM_WIDTH  BRAM read data.
m_valid  out  1  output word valid.
m_data  out  RAM_WIDTH  output word.
m_last  out  1  marks the final word of the burst.
m_ready  in  1  consumer accepts.
busy  out  1  high outside IDLE.
done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Interface decision: one clock, clk; reset rst, synchronous and active-high.
- Reset values: cmd_ready=1, enb=0, addrb=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. Output FIFO is emptied and the in-flight flag is cleared.
- BRAM timing: addrb and enb are registered on posedge t. The BRAM samples them on the following negedge. doutb is captured into the FIFO at posedge t+1, so read latency is 1 cycle. enb is low whenever no read is issued, which keeps doutb stable.
- States:
  - IDLE: on cmd_valid && cmd_ready, latch base/len. If len==0, go to DONE. Otherwise go to RUN.
  - RUN: issue reads until remaining==0, then go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Issue rule (RUN): issue when remaining>0 && (count + inflight - pop) < 2.
  - pop = m_valid && m_ready.
  - count is the occupancy of the 2-entry output FIFO.
  - inflight is 1 if a read was issued in the previous cycle.
  - Invariant: count + inflight <= 2. This guarantees no overflow and no lost data.
- On each issue: addrb = current address. The address then increments modulo RAM_DEPTH, so base=250, len=10 wraps to 0..3. remaining decrements on each issue.
- Throughput: with m_ready held high, one word per cycle after 2 cycles of startup latency (command accept, issue, capture).
- Stream rules:
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - m_valid never drops without a handshake.
  - Words are emitted in address order.
  - m_last=1 exactly on the len-th word.
- done: asserted the cycle after the handshake of the m_last word. For len==0, done is asserted 1 cycle after command accept and no beats are emitted.
- Commands offered while busy are not accepted; cmd_ready=0.
- A pop and a capture in the same cycle with the FIFO full is legal, because the issue rule reserves the slot.
- Reset mid-burst: aborts immediately with no done pulse. The FIFO is flushed, and any stale doutb is ignored because inflight is cleared.
- cmd_len > RAM_DEPTH is illegal; the bench asserts it never occurs.

Decomposition:
- Shared package: clogb2 function, default RAM_WIDTH/RAM_DEPTH constants, state encoding localparams (IDLE, RUN, DRAIN, DONE).
- One sub-module: stream_fifo2, a 2-entry synchronous FIFO with push/pop/count, data+last payload, and sync active-high reset. The top level holds the FSM, address/remaining counters, and the inflight flag.

Test Plan:
- BRAM preloaded with bram[i]=i. Command base=0, len=4, m_ready=1 -> data 0,1,2,3 on 4 consecutive cycles, m_last on 3, done 1 cycle later.
- base=254, len=4 -> words 254,255,0,1, with addrb wrapping to 0.
- base=10, len=6, m_ready toggling 1,0,0,1,0,1... -> exactly 10..15 in order, no duplicates or drops, data stable during stalls, count never >2.
- len=0 -> no m_valid, done 1 cycle after accept; cmd_ready back high the cycle after done.
- base=0, len=256, m_ready=1 -> 256 words 0..255 with back-to-back valid; exactly one m_last and one done.
- rst asserted after 3 beats of len=8 -> next cycle all outputs at reset values, no done. A new command base=100, len=2 then returns 100,101 only.
